// File: rtl/pong_pkg.sv
// Shared Pong definitions: match-state encoding, winner codes and VGA frame geometry.
`default_nettype none

package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  localparam int TOTAL_H  = 800;
  localparam int TOTAL_V  = 525;
  localparam int ACTIVE_H = 640;
  localparam int ACTIVE_V = 480;

endpackage

`default_nettype wire

// File: rtl/pong_game_ctrl_if.sv
// Game-flow bundle between the event sources (UART, sync, ball datapath) and the match controller.
`default_nettype none

interface pong_game_ctrl_if #(
  parameter int SCORE_WIDTH = 4
);
  logic                   game_start_i;
  logic                   frame_tick_i;
  logic                   p1_miss_i;
  logic                   p2_miss_i;
  logic                   ball_enable_o;
  logic                   ball_center_o;
  logic                   serve_dir_o;
  logic [SCORE_WIDTH-1:0] p1_score_o;
  logic [SCORE_WIDTH-1:0] p2_score_o;
  logic [1:0]             winner_o;
  logic [2:0]             state_o;

  modport master (
    output game_start_i, frame_tick_i, p1_miss_i, p2_miss_i,
    input  ball_enable_o, ball_center_o, serve_dir_o,
           p1_score_o, p2_score_o, winner_o, state_o
  );

  modport slave (
    input  game_start_i, frame_tick_i, p1_miss_i, p2_miss_i,
    output ball_enable_o, ball_center_o, serve_dir_o,
           p1_score_o, p2_score_o, winner_o, state_o
  );
endinterface

`default_nettype wire

// File: rtl/frame_delay_counter.sv
// Counts frame ticks while not cleared; done pulses on the tick that reaches the terminal count.
`default_nettype none

module frame_delay_counter #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk_i,
  input  wire logic             rst_i,
  input  wire logic             clear,
  input  wire logic             frame_tick_i,
  input  wire logic [WIDTH-1:0] terminal,
  output logic                  done
);

  logic [WIDTH-1:0] count;

  assign done = !clear && frame_tick_i && (count == terminal);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear || done) begin
      count <= '0;
    end else if (frame_tick_i) begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: serve/rally/point/game-over flow, score keeping and ball gating.
`default_nettype none

module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int SCORE_LIMIT     = 9,
  parameter int SCORE_WIDTH     = 4,
  parameter int SERVE_FRAMES    = 60,
  parameter int POINT_FRAMES    = 30,
  parameter int FRAME_CNT_WIDTH = 8
) (
  input  wire logic       clk_i,
  input  wire logic       rst_i,
  pong_game_ctrl_if.slave bus
);

  localparam logic [SCORE_WIDTH-1:0]     SCORE_MAX = '1;
  localparam logic [SCORE_WIDTH-1:0]     LIMIT     = SCORE_WIDTH'(SCORE_LIMIT);
  localparam logic [FRAME_CNT_WIDTH-1:0] SERVE_TC  = FRAME_CNT_WIDTH'(SERVE_FRAMES - 1);
  localparam logic [FRAME_CNT_WIDTH-1:0] POINT_TC  = FRAME_CNT_WIDTH'(POINT_FRAMES - 1);

  state_t                     state, state_nx;
  logic [SCORE_WIDTH-1:0]     p1_score, p1_nx;
  logic [SCORE_WIDTH-1:0]     p2_score, p2_nx;
  logic [1:0]                 winner, winner_nx;
  logic                       serve_dir, serve_dir_nx;
  logic                       ball_enable, ball_center;
  logic                       delay_clear, delay_done;
  logic [FRAME_CNT_WIDTH-1:0] terminal;

  // Counter is held clear outside the delay states, so a tick on the entry cycle is never counted.
  assign delay_clear = !(state == ST_SERVE || state == ST_POINT);
  assign terminal    = (state == ST_POINT) ? POINT_TC : SERVE_TC;

  frame_delay_counter #(
    .WIDTH (FRAME_CNT_WIDTH)
  ) u_delay (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear        (delay_clear),
    .frame_tick_i (bus.frame_tick_i),
    .terminal     (terminal),
    .done         (delay_done)
  );

  always_comb begin
    state_nx     = state;
    p1_nx        = p1_score;
    p2_nx        = p2_score;
    winner_nx    = winner;
    serve_dir_nx = serve_dir;
    case (state)
      ST_IDLE, ST_OVER: begin
        if (bus.game_start_i) begin
          state_nx     = ST_SERVE;
          p1_nx        = '0;
          p2_nx        = '0;
          winner_nx    = WIN_NONE;
          serve_dir_nx = 1'b0;
        end
      end
      ST_SERVE: begin
        if (delay_done) state_nx = ST_PLAY;
      end
      ST_PLAY: begin
        case ({bus.p1_miss_i, bus.p2_miss_i})
          2'b10: begin
            p2_nx        = (p2_score == SCORE_MAX) ? p2_score : p2_score + 1'b1;
            serve_dir_nx = 1'b1;
            state_nx     = ST_POINT;
          end
          2'b01: begin
            p1_nx        = (p1_score == SCORE_MAX) ? p1_score : p1_score + 1'b1;
            serve_dir_nx = 1'b0;
            state_nx     = ST_POINT;
          end
          2'b11: begin
            serve_dir_nx = !serve_dir;
            state_nx     = ST_POINT;
          end
          default: ;
        endcase
      end
      ST_POINT: begin
        if (delay_done) begin
          if (p1_score >= LIMIT) begin
            winner_nx = WIN_P1;
            state_nx  = ST_OVER;
          end else if (p2_score >= LIMIT) begin
            winner_nx = WIN_P2;
            state_nx  = ST_OVER;
          end else begin
            state_nx  = ST_SERVE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Ball gating is registered from the next state so it lines up with state_o.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      p1_score    <= '0;
      p2_score    <= '0;
      winner      <= WIN_NONE;
      serve_dir   <= 1'b0;
      ball_enable <= 1'b0;
      ball_center <= 1'b1;
    end else begin
      state       <= state_nx;
      p1_score    <= p1_nx;
      p2_score    <= p2_nx;
      winner      <= winner_nx;
      serve_dir   <= serve_dir_nx;
      ball_enable <= (state_nx == ST_PLAY);
      ball_center <= (state_nx != ST_PLAY);
    end
  end

  assign bus.state_o       = state;
  assign bus.p1_score_o    = p1_score;
  assign bus.p2_score_o    = p2_score;
  assign bus.winner_o      = winner;
  assign bus.serve_dir_o   = serve_dir;
  assign bus.ball_enable_o = ball_enable;
  assign bus.ball_center_o = ball_center;

endmodule

`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed match scenarios plus random traffic against a behavioural model.
`default_nettype none

module tb_pong_game_ctrl;

  localparam int SCORE_LIMIT  = 9;
  localparam int SCORE_WIDTH  = 4;
  localparam int SERVE_FRAMES = 60;
  localparam int POINT_FRAMES = 30;
  localparam int SCORE_SAT    = (1 << SCORE_WIDTH) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pong_game_ctrl_if #(.SCORE_WIDTH(SCORE_WIDTH)) bus ();

  pong_game_ctrl #(
    .SCORE_LIMIT     (SCORE_LIMIT),
    .SCORE_WIDTH     (SCORE_WIDTH),
    .SERVE_FRAMES    (SERVE_FRAMES),
    .POINT_FRAMES    (POINT_FRAMES),
    .FRAME_CNT_WIDTH (8)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: match phase plus a countdown of frame ticks still to wait in the current delay.
  int m_phase = 0;
  int m_p1 = 0, m_p2 = 0, m_win = 0, m_dir = 0, m_left = 0;

  function automatic int sat_inc(input int v);
    return (v >= SCORE_SAT) ? SCORE_SAT : v + 1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_p1 = 0; m_p2 = 0; m_win = 0; m_dir = 0; m_left = 0;
    end else if (m_phase == 0 || m_phase == 4) begin
      if (bus.game_start_i) begin
        m_phase = 1; m_p1 = 0; m_p2 = 0; m_win = 0; m_dir = 0; m_left = SERVE_FRAMES;
      end
    end else if (m_phase == 1) begin
      if (bus.frame_tick_i) begin
        m_left = m_left - 1;
        if (m_left == 0) m_phase = 2;
      end
    end else if (m_phase == 2) begin
      if (bus.p1_miss_i || bus.p2_miss_i) begin
        if (bus.p1_miss_i && bus.p2_miss_i) m_dir = 1 - m_dir;
        else if (bus.p1_miss_i) begin m_p2 = sat_inc(m_p2); m_dir = 1; end
        else begin m_p1 = sat_inc(m_p1); m_dir = 0; end
        m_phase = 3;
        m_left  = POINT_FRAMES;
      end
    end else if (m_phase == 3) begin
      if (bus.frame_tick_i) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          if (m_p1 >= SCORE_LIMIT) begin m_win = 1; m_phase = 4; end
          else if (m_p2 >= SCORE_LIMIT) begin m_win = 2; m_phase = 4; end
          else begin m_phase = 1; m_left = SERVE_FRAMES; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("state_o",       bus.state_o,       m_phase);
      chk("ball_enable_o", bus.ball_enable_o, (m_phase == 2));
      chk("ball_center_o", bus.ball_center_o, (m_phase != 2));
      chk("serve_dir_o",   bus.serve_dir_o,   m_dir);
      chk("p1_score_o",    bus.p1_score_o,    m_p1);
      chk("p2_score_o",    bus.p2_score_o,    m_p2);
      chk("winner_o",      bus.winner_o,      m_win);
    end
  end

  task automatic step(input bit s, input bit t, input bit a, input bit b, input bit r);
    bus.game_start_i = s; bus.frame_tick_i = t; bus.p1_miss_i = a; bus.p2_miss_i = b; rst = r;
    @(posedge clk); #1;
    bus.game_start_i = 1'b0; bus.frame_tick_i = 1'b0; bus.p1_miss_i = 1'b0; bus.p2_miss_i = 1'b0; rst = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 1, 0, 0, 0);
      repeat (3) step(0, 0, 0, 0, 0);
    end
  endtask

  // From PLAY: loser misses, then the point hold and the next serve run out.
  task automatic win_point(input int who);
    step(0, 0, who == 2, who == 1, 0);
    frames(POINT_FRAMES);
    frames(SERVE_FRAMES);
  endtask

  initial begin
    bus.game_start_i = 1'b0; bus.frame_tick_i = 1'b0; bus.p1_miss_i = 1'b0; bus.p2_miss_i = 1'b0;
    step(0, 0, 0, 0, 1);
    checking = 1'b1;
    step(0, 0, 0, 0, 1);
    chk("reset state", bus.state_o, 0);
    chk("reset enable", bus.ball_enable_o, 0);
    chk("reset center", bus.ball_center_o, 1);
    chk("reset p1", bus.p1_score_o, 0);

    for (int i = 0; i < 200; i++) begin
      step(0, 1, i % 7 == 0, i % 11 == 0, 0);
      repeat (3) step(0, 0, 0, 0, 0);
    end
    chk("idle 200 frames state", bus.state_o, 0);
    chk("idle 200 frames p2", bus.p2_score_o, 0);

    step(1, 1, 0, 0, 0);
    chk("start -> serve", bus.state_o, 1);
    frames(SERVE_FRAMES - 1);
    chk("serve tick 59 enable", bus.ball_enable_o, 0);
    frames(1);
    chk("serve done state", bus.state_o, 2);
    chk("serve done enable", bus.ball_enable_o, 1);

    step(0, 0, 0, 1, 0);
    chk("p2 miss p1 score", bus.p1_score_o, 1);
    chk("p2 miss dir", bus.serve_dir_o, 0);
    chk("p2 miss state", bus.state_o, 3);
    frames(POINT_FRAMES);
    chk("point hold -> serve", bus.state_o, 1);
    frames(SERVE_FRAMES);

    step(0, 0, 1, 1, 0);
    chk("double miss dir", bus.serve_dir_o, 1);
    chk("double miss p1", bus.p1_score_o, 1);
    chk("double miss p2", bus.p2_score_o, 0);
    chk("double miss state", bus.state_o, 3);
    frames(POINT_FRAMES + SERVE_FRAMES);

    for (int pt = 2; pt <= SCORE_LIMIT; pt++) begin
      step(0, 0, 0, 1, 0);
      frames(POINT_FRAMES);
      if (pt < SCORE_LIMIT) frames(SERVE_FRAMES);
    end
    chk("game over state", bus.state_o, 4);
    chk("game over winner", bus.winner_o, 1);
    step(0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("over frozen p1", bus.p1_score_o, 9);
    chk("over frozen p2", bus.p2_score_o, 0);
    step(1, 0, 0, 0, 0);
    chk("restart state", bus.state_o, 1);
    chk("restart p1", bus.p1_score_o, 0);
    chk("restart winner", bus.winner_o, 0);

    frames(30);
    step(0, 0, 0, 0, 1);
    chk("rst mid-serve state", bus.state_o, 0);
    step(1, 0, 0, 0, 0);
    frames(SERVE_FRAMES - 1);
    chk("counter restarted", bus.state_o, 1);
    frames(1);
    win_point(1); win_point(2); win_point(1); win_point(2); win_point(1);
    chk("3-2 p1", bus.p1_score_o, 3);
    chk("3-2 p2", bus.p2_score_o, 2);
    step(0, 0, 0, 0, 1);
    chk("rst mid-play state", bus.state_o, 0);
    chk("rst mid-play p1", bus.p1_score_o, 0);

    for (int i = 0; i < 8000; i++) begin
      step($urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 1999) == 0);
    end

    @(negedge clk);
    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game-flow sequencer for Pong. It sits between the UART start pulse, the ball/paddle datapath and the score renderer. It runs the match state machine (idle, serve delay, rally, point hold, game over), keeps both players' scores, and gates and re-centres the ball. All timing is counted in video frames using a one-cycle frame tick from the sync generator.

Parameters:
SCORE_LIMIT, 9, points needed to win; legal range 1..2^SCORE_WIDTH-1
SCORE_WIDTH, 4, width of each score counter
SERVE_FRAMES, 60, frames the ball is held centred before a serve
POINT_FRAMES, 30, frames held after a point before the score is checked
FRAME_CNT_WIDTH, 8, width of the frame delay counter; must hold max(SERVE_FRAMES, POINT_FRAMES)

Ports:
clk_i  input  1  system clock (25 MHz pixel clock)
rst_i  input  1  synchronous, active-high reset
game_start_i  input  1  one-cycle start pulse (UART rx data valid)
frame_tick_i  input  1  one-cycle pulse at start of each frame
p1_miss_i  input  1  one-cycle pulse: ball passed P1 paddle (point to P2)
p2_miss_i  input  1  one-cycle pulse: ball passed P2 paddle (point to P1)
ball_enable_o  output  1  ball may move (high only in PLAY)
ball_center_o  output  1  ball held at screen centre
serve_dir_o  output  1  0 = serve toward P2 (right), 1 = toward P1 (left)
p1_score_o  output  SCORE_WIDTH  player 1 score
p2_score_o  output  SCORE_WIDTH  player 2 score
winner_o  output  2  00 none, 01 P1, 10 P2
state_o  output  3  encoded state, for debug and display

Behaviour:
- Reset: state IDLE, scores 0, winner_o 00, serve_dir_o 0, frame counter 0, ball_enable_o 0, ball_center_o 1.
- Reset takes priority over all inputs in any state, including mid-rally and mid-delay.
- All outputs are registered; state_o changes in the cycle after the causing event.
- State encoding: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.
- IDLE:
  - game_start_i -> SERVE.
  - On that transition: clear scores, winner_o=00, serve_dir_o=0, frame counter=0.
  - Miss pulses are ignored.
- SERVE:
  - ball_center_o=1, ball_enable_o=0.
  - Frame counter increments on each frame_tick_i.
  - When counter==SERVE_FRAMES-1 and frame_tick_i: go to PLAY and clear the counter.
  - Miss pulses and game_start_i are ignored.
- PLAY:
  - ball_enable_o=1, ball_center_o=0.
  - p1_miss_i alone: p2_score+1, serve_dir_o=1 (serve toward the loser, P1), go to POINT.
  - p2_miss_i alone: p1_score+1, serve_dir_o=0, go to POINT.
  - Both miss pulses in the same cycle: no score change, serve_dir_o toggles, go to POINT.
  - game_start_i is ignored.
- POINT:
  - ball_enable_o=0, ball_center_o=1.
  - Counts POINT_FRAMES frame ticks, same rule as SERVE.
  - On expiry: if p1_score>=SCORE_LIMIT then winner=01 and go to OVER; else if p2_score>=SCORE_LIMIT then winner=10 and go to OVER; else go to SERVE.
  - The counter is cleared on every exit.
- OVER:
  - ball_enable_o=0, ball_center_o=1; scores and winner frozen.
  - game_start_i -> SERVE with the same clearing as from IDLE.
- Score width rules:
  - Scores saturate at 2^SCORE_WIDTH-1 and never wrap.
  - Scores change only in PLAY.
- A frame_tick_i coincident with a state entry does not count toward the new delay.
- Unused state encodings (5..7) return to IDLE on the next cycle.

Decomposition:
- Shared package pong_pkg: state encoding constants and winner codes (NONE/P1/P2). The VGA/Pong modules already share the TOTAL_/ACTIVE_ geometry parameters; those belong in the same package.
- One natural sub-module: frame_delay_counter.
  - Inputs: clk_i, rst_i, clear, frame_tick_i, terminal count.
  - Output: a one-cycle done pulse.
  - Instantiated once and shared by SERVE and POINT.
- The FSM and score registers stay in pong_game_ctrl.

Test Plan:
- Reset then no stimulus for 200 frames -> state_o=0, ball_enable_o=0, ball_center_o=1, scores 0.
- game_start_i pulse -> state_o=1 next cycle; exactly 60 frame ticks later state_o=2 and ball_enable_o=1; ball_enable_o is low at tick 59.
- In PLAY, p2_miss_i pulse -> p1_score_o=1, serve_dir_o=0, state_o=3; after 30 ticks state_o=1.
- Simultaneous p1_miss_i and p2_miss_i with serve_dir_o=0 -> scores unchanged, serve_dir_o=1, state_o=3.
- P1 scores 9 points (SCORE_LIMIT=9) -> after the final POINT delay state_o=4 and winner_o=01; further misses leave scores at 9; game_start_i -> scores 0, winner_o=00, state_o=1.
- rst_i asserted mid-SERVE at tick 30, and separately mid-PLAY with score 3-2 -> next cycle state_o=0, scores 0, counter restarts from 0 on the next start.
